// File: rtl/io_bus_master.sv
// -----------------------------------------------------------------------------
// io_bus_master
//
// Two-requester master for the shared register I/O bus. It arbitrates
// round-robin between two requesters. It then runs one four-phase
// handshake per transaction:
//   SETUP   - drive address/RW/data with register_address_valid
//   STROBE  - raise handshake_1 and wait for handshake_2
//   RELEASE - drop handshake_1 and wait for handshake_2 to fall
//   DONE    - pulse the requester's ack and publish status
// Finally it returns to IDLE.
//
// Optional feature macro: IO_BUS_TIMEOUT_EN
//   When defined, a 16-bit counter bounds the wait for each handshake_2
//   edge to TIMEOUT_CYCLES cycles. On expiry the transaction ends with
//   status TIMEOUT. When undefined, STROBE and RELEASE wait indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles waited per handshake_2 edge (1..65535)
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous active-low reset
//   data_out     [31:0]     bus write data (0 during reads)
//   reg_address  [7:0]      bus register address
//   rw                      bus direction, 1 = read, 0 = write
//   handshake_1             master strobe, high only in STROBE
//   register_address_valid  high in SETUP, STROBE and RELEASE
//   data_in      [31:0]     bus read data from the slave
//   handshake_2             slave handshake
//   n_fault                 slave fault flag, active low
//   req_0/req_1             transaction requests, held until ack
//   addr_0/addr_1 [7:0]     per-requester target address
//   rw_0/rw_1               per-requester direction
//   wdata_0/wdata_1 [31:0]  per-requester write data
//   ack_0/ack_1             one-cycle completion pulse
//   rdata        [31:0]     data of the last completed read
//   status       [1:0]      00 OK, 01 FAULT, 10 TIMEOUT
//   busy                    high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module io_bus_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] data_out,
   output logic [7:0]  reg_address,
   output logic        rw,
   output logic        handshake_1,
   output logic        register_address_valid,
   input  logic [31:0] data_in,
   input  logic        handshake_2,
   input  logic        n_fault,
   input  logic        req_0,
   input  logic        req_1,
   input  logic [7:0]  addr_0,
   input  logic [7:0]  addr_1,
   input  logic        rw_0,
   input  logic        rw_1,
   input  logic [31:0] wdata_0,
   input  logic [31:0] wdata_1,
   output logic        ack_0,
   output logic        ack_1,
   output logic [31:0] rdata,
   output logic [1:0]  status,
   output logic        busy
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SETUP   = 3'd1;
   localparam logic [2:0] STROBE  = 3'd2;
   localparam logic [2:0] RELEASE = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_FAULT   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
      $error("io_bus_master: TIMEOUT_CYCLES must be within 1..65535");
   end

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   // Requester currently/last granted; doubles as the round-robin pointer.
   logic        grant;
   logic        pick;
   logic        pick_rw;
   logic [7:0]  addr_q;
   logic        rw_q;
   logic [31:0] dout_q;
   logic        fault_q;
   logic [31:0] rdata_q;
   logic [1:0]  status_q;
   logic        timeout_hit;

   // On a tie, serve the requester that did not win last time; otherwise
   // the lone requester wins (req_1 alone selects 1, req_0 alone selects 0).
   assign pick    = (req_0 && req_1) ? ~grant : req_1;
   assign pick_rw = pick ? rw_1 : rw_0;

`ifdef IO_BUS_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt;

   // Counts cycles spent in the current wait state; it restarts on every
   // state change, so entering STROBE or RELEASE always starts from zero.
   // Hitting TMO_LAST in the wait state's TIMEOUT_CYCLES-th cycle means
   // exactly TIMEOUT_CYCLES cycles are spent waiting for the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (state_nxt != state) begin
         tmo_cnt <= '0;
      end else if (state == STROBE || state == RELEASE) begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   assign timeout_hit = (state == STROBE || state == RELEASE) && (tmo_cnt == TMO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_0 || req_1) state_nxt = SETUP;
         SETUP:   state_nxt = STROBE;
         // A slave answer in the same cycle as expiry still counts.
         STROBE:  if (handshake_2) state_nxt = RELEASE;
                  else if (timeout_hit) state_nxt = DONE;
         RELEASE: if (!handshake_2 || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         grant    <= 1'b1;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         dout_q   <= '0;
         fault_q  <= 1'b0;
         rdata_q  <= '0;
         status_q <= ST_OK;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req_0 || req_1) begin
                  grant  <= pick;
                  addr_q <= pick ? addr_1 : addr_0;
                  rw_q   <= pick_rw;
                  dout_q <= pick_rw ? 32'd0 : (pick ? wdata_1 : wdata_0);
               end
            end
            STROBE: begin
               if (handshake_2) begin
                  fault_q <= ~n_fault;
                  if (rw_q) rdata_q <= data_in;
               end else if (timeout_hit) begin
                  status_q <= ST_TIMEOUT;
               end
            end
            // Status is written on the way into DONE so it is valid with ack.
            RELEASE: begin
               if (!handshake_2) begin
                  status_q <= fault_q ? ST_FAULT : ST_OK;
               end else if (timeout_hit) begin
                  status_q <= ST_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   // Bus strobes decode straight from the state register so an
   // asynchronous reset releases the bus in the same cycle.
   assign handshake_1            = (state == STROBE);
   assign register_address_valid = (state == SETUP) || (state == STROBE) || (state == RELEASE);
   assign busy                   = (state != IDLE);
   assign ack_0                  = (state == DONE) && !grant;
   assign ack_1                  = (state == DONE) && grant;
   assign reg_address            = addr_q;
   assign rw                     = rw_q;
   assign data_out               = dout_q;
   assign rdata                  = rdata_q;
   assign status                 = status_q;

endmodule
